regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between NUM_SRC writeback requesters (ALU, load unit, CSR, ...).
//  Arbitrates them round-robin, one write per cycle, and drives the regfile write index and data from registers.
//  Keeps a per-register pending scoreboard and reports read-after-write hazards to the decode stage.
//  Sits between the execute/memory units and the register file, next to decode.
// PARAMETERS
//  NUM_SRC  3   number of writeback requesters (2..8)
//  IDX_W    5   register index width (32 registers, x0 hardwired zero)
//  DATA_W   32  register data width
// PORTS
//  clk          in   1                clock, all state on posedge
//  reset        in   1                synchronous, active-high
//  src_valid    in   NUM_SRC          requester i has a write pending
//  src_ready    out  NUM_SRC          one-hot grant; write accepted when valid&ready
//  src_idx      in   NUM_SRC*IDX_W    dest index of requester i, slice [i*IDX_W +: IDX_W]
//  src_data     in   NUM_SRC*DATA_W   write data of requester i, slice [i*DATA_W +: DATA_W]
//  idx_write    out  IDX_W            to regfile write index (0 = no write)
//  data_write   out  DATA_W           to regfile write data
//  issue_valid  in   1                decode issues an instruction that writes issue_rd
//  issue_rd     in   IDX_W            destination of issued instruction
//  rs1, rs2     in   IDX_W            decode source indices
//  hazard       out  1                rs1 or rs2 has a write outstanding
//  pending_cnt  out  IDX_W+1          number of registers currently marked pending
// BEHAVIOUR
//  Reset (sync): idx_write=0, data_write=0, pending[31:0]=0, pending_cnt=0, rr_ptr=0.
//   src_ready=0 and hazard=0 in the reset cycle. Reset mid-operation drops every in-flight and pending write.
//  Arbitration (combinational grant, registered output):
//   - Search starts at rr_ptr, wraps modulo NUM_SRC; the first valid source wins. At most one src_ready bit is high.
//   - src_ready[i] is never high unless src_valid[i]; a requester holds valid/idx/data stable until ready.
//   - On accept: rr_ptr <= (granted+1) mod NUM_SRC. With no valid source, rr_ptr holds.
//   - Next cycle: idx_write<=src_idx[g], data_write<=src_data[g]. With no grant: idx_write<=0, data_write<=0.
//   - Regfile captures at the following edge: accept to visible-on-read latency is 2 edges.
//   - Accepted src_idx==0 counts as a grant (pointer advances) but produces idx_write=0.
//  Scoreboard:
//   - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the edge.
//   - Clear: idx_write!=0 clears pending[idx_write] at the same edge the regfile captures the data.
//   - Set and clear on the same index at the same edge: set wins, because a newer write is outstanding.
//   - pending[0] is never set.
//   - Issue to an already-pending index: stays pending; no counting of multiple in-flight writes per index.
//   - hazard = pending[rs1] | pending[rs2], combinational; an index of 0 contributes 0.
//   - pending_cnt is a registered popcount of the next pending vector. It always equals popcount(pending).
//  Reset has priority over all writes, issues and grants in the same cycle.
// TESTING
//  1 Reset, no activity -> idx_write=0, data_write=0, hazard=0, pending_cnt=0 for 10 cycles.
//  2 Only src1 valid, idx=5, data=0xDEADBEEF -> src_ready=3'b010 that cycle;
//    next cycle idx_write=5, data_write=0xDEADBEEF; the cycle after, idx_write=0.
//  3 All 3 valid, held for 6 cycles, rr_ptr=0 -> grant order 0,1,2,0,1,2; each requester gets 2 writes.
//  4 issue rd=7, then rs1=7 -> hazard=1, pending_cnt=1;
//    src0 writes idx 7 -> hazard=0 from the cycle after idx_write=7, pending_cnt=0.
//  5 issue_rd=9 set on the same edge that idx_write=9 clears -> pending[9] stays 1, hazard stays 1 for rs2=9.
//  6 issue rd=0 and src write idx 0 -> pending_cnt=0, idx_write=0;
//    reset asserted with 3 pending -> all cleared at the next edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between NUM_SRC writeback
//   requesters (ALU, load unit, CSR, ...). Requesters are served round-robin,
//   one write per cycle, and the regfile write index/data come from registers.
//   A per-register pending scoreboard flags read-after-write hazards to decode.
//
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous, active-high; drops all in-flight and pending writes
//   src_valid    per-requester write request
//   src_ready    one-hot grant (combinational); write accepted when valid&ready
//   src_idx      dest index of requester i at [i*IDX_W +: IDX_W]
//   src_data     write data of requester i at [i*DATA_W +: DATA_W]
//   idx_write    regfile write index, registered (0 = no write)
//   data_write   regfile write data, registered
//   issue_valid  decode issues an instruction writing issue_rd
//   issue_rd     destination of the issued instruction
//   rs1, rs2     decode source indices
//   hazard       rs1 or rs2 has a write outstanding (combinational)
//   pending_cnt  number of registers currently marked pending (registered)
module regfile_wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*IDX_W-1:0]  src_idx,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [IDX_W-1:0]          idx_write,
    output logic [DATA_W-1:0]         data_write,
    input  logic                      issue_valid,
    input  logic [IDX_W-1:0]          issue_rd,
    input  logic [IDX_W-1:0]          rs1,
    input  logic [IDX_W-1:0]          rs2,
    output logic                      hazard,
    output logic [IDX_W:0]            pending_cnt
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NREG  = 1 << IDX_W;
    localparam logic [PTR_W:0]   NSRC = (PTR_W+1)'(NUM_SRC);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SRC - 1);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_idx_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [NREG-1:0]   r_pending;
    logic [IDX_W:0]    r_cnt;

    logic              w_found;
    logic [PTR_W-1:0]  w_gidx;
    logic [PTR_W:0]    w_sum;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W-1:0] w_sel_data;
    logic [PTR_W-1:0]  w_ptr_next;
    logic [NREG-1:0]   w_pend_next;
    logic [IDX_W:0]    w_cnt_next;

    // Stage p0: round-robin search starting at r_rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= NSRC) begin
                w_sum = w_sum - NSRC;
            end
            if (!w_found && src_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[PTR_W-1:0];
            end
        end
        // No grant while in reset, so nothing is accepted that would be dropped.
        if (reset) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        src_ready  = '0;
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_found && (w_gidx == PTR_W'(i))) begin
                src_ready[i] = 1'b1;
                w_sel_idx    = src_idx[i*IDX_W +: IDX_W];
                w_sel_data   = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_gidx == LAST) ? '0 : w_gidx + 1'b1;

    // Scoreboard: clear on the edge the regfile captures r_idx_p1; a same-index
    // issue on that edge wins because it represents a newer outstanding write.
    always_comb begin
        w_pend_next = r_pending;
        if (r_idx_p1 != '0) begin
            w_pend_next[r_idx_p1] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_pend_next[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_next = w_cnt_next + (IDX_W+1)'(w_pend_next[r]);
        end
    end

    // Stage p1: registered regfile write port, pointer and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_idx_p1  <= '0;
            r_data_p1 <= '0;
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_found) begin
                r_rr_ptr  <= w_ptr_next;
                r_idx_p1  <= w_sel_idx;
                r_data_p1 <= w_sel_data;
            end else begin
                r_idx_p1  <= '0;
                r_data_p1 <= '0;
            end
            r_pending <= w_pend_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign idx_write   = r_idx_p1;
    assign data_write  = r_data_p1;
    assign pending_cnt = r_cnt;
    // Index 0 never has a pending write, so it never raises a hazard.
    assign hazard = !reset && (((rs1 != '0) && r_pending[rs1]) ||
                               ((rs2 != '0) && r_pending[rs2]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a per-cycle reference model with a
// write-port scoreboard, plus directed scenario checks.
module tb_regfile_wb_arbiter;

    localparam int NS = 3;
    localparam int IW = 5;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS*IW-1:0] src_idx;
    logic [NS*DW-1:0] src_data;
    logic [IW-1:0]    idx_write;
    logic [DW-1:0]    data_write;
    logic             issue_valid;
    logic [IW-1:0]    issue_rd;
    logic [IW-1:0]    rs1;
    logic [IW-1:0]    rs2;
    logic             hazard;
    logic [IW:0]      pending_cnt;

    regfile_wb_arbiter #(.NUM_SRC(NS), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_idx(src_idx), .src_data(src_data),
        .idx_write(idx_write), .data_write(data_write),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2),
        .hazard(hazard), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    int          m_rr     = 0;
    logic [31:0] m_pend   = '0;
    wr_t         sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: compares every cycle at negedge, then advances to the
    // state the DUT should hold after the next posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NS-1:0] er;
            int            g;
            bit            found;
            wr_t           e;
            logic [31:0]   np;
            logic          eh;
            found = 1'b0;
            g     = 0;
            er    = '0;
            if (!reset) begin
                for (int k = 0; k < NS; k++) begin
                    int j;
                    j = (m_rr + k) % NS;
                    if (!found && src_valid[j]) begin
                        found = 1'b1;
                        g     = j;
                    end
                end
                if (found) er[g] = 1'b1;
            end
            check_eq("src_ready", src_ready, er);
            check_eq("sb_nonempty", sb_q.size() > 0, 1);
            e = '0;
            if (sb_q.size() > 0) e = sb_q.pop_front();
            check_eq("idx_write", idx_write, e.idx);
            check_eq("data_write", data_write, e.data);
            eh = !reset && (((rs1 != 0) && m_pend[rs1]) || ((rs2 != 0) && m_pend[rs2]));
            check_eq("hazard", hazard, eh);
            check_eq("pending_cnt", pending_cnt, $countones(m_pend));
            if (reset) begin
                m_pend = '0;
                m_rr   = 0;
                sb_q.push_back('0);
            end else begin
                np = m_pend;
                if (e.idx != 0) np[e.idx] = 1'b0;
                if (issue_valid && issue_rd != 0) np[issue_rd] = 1'b1;
                m_pend = np;
                if (found) begin
                    m_rr = (g + 1) % NS;
                    sb_q.push_back({src_idx[g*IW +: IW], src_data[g*DW +: DW]});
                end else begin
                    sb_q.push_back('0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid   = '0;
        src_idx     = '0;
        src_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] ord [6];
        int            cnt [NS];
        ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset = 1'b1;
        idle();
        sb_q.push_back('0);
        tick();
        mon_en = 1'b1;
        tick();

        // 1: idle after reset
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t1_idx", idx_write, 0);
            check_eq("t1_data", data_write, 0);
            check_eq("t1_hazard", hazard, 0);
            check_eq("t1_cnt", pending_cnt, 0);
            tick();
        end

        // 2: single requester src1
        src_valid            = 3'b010;
        src_idx[1*IW +: IW]  = 5'd5;
        src_data[1*DW +: DW] = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("t2_ready", src_ready, 3'b010);
        tick();
        idle();
        @(negedge clk);
        check_eq("t2_idx", idx_write, 5);
        check_eq("t2_data", data_write, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check_eq("t2_idx_after", idx_write, 0);
        tick();

        // 3: all valid, round-robin from pointer 0
        do_reset();
        src_valid = 3'b111;
        for (int i = 0; i < NS; i++) begin
            src_idx[i*IW +: IW]  = IW'(10 + i);
            src_data[i*DW +: DW] = 32'hA0 + i;
            cnt[i] = 0;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("t3_order", src_ready, ord[c]);
            for (int i = 0; i < NS; i++) if (src_ready[i]) cnt[i]++;
            tick();
        end
        idle();
        for (int i = 0; i < NS; i++) check_eq("t3_count", cnt[i], 2);
        tick();

        // 4: RAW hazard set by issue, cleared by writeback
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1         = 5'd7;
        @(negedge clk);
        check_eq("t4_hazard_set", hazard, 1);
        check_eq("t4_cnt_set", pending_cnt, 1);
        tick();
        src_valid            = 3'b001;
        src_idx[0 +: IW]     = 5'd7;
        src_data[0 +: DW]    = 32'h77;
        @(negedge clk);
        check_eq("t4_ready", src_ready, 3'b001);
        tick();
        src_valid = '0;
        @(negedge clk);
        check_eq("t4_idx", idx_write, 7);
        check_eq("t4_hazard_wb", hazard, 1);
        tick();
        @(negedge clk);
        check_eq("t4_hazard_clr", hazard, 0);
        check_eq("t4_cnt_clr", pending_cnt, 0);
        tick();
        idle();

        // 5: set and clear of the same index on one edge, set wins
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid           = 1'b0;
        rs2                   = 5'd9;
        src_valid             = 3'b010;
        src_idx[1*IW +: IW]   = 5'd9;
        src_data[1*DW +: DW]  = 32'h99;
        tick();
        src_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        @(negedge clk);
        check_eq("t5_idx", idx_write, 9);
        check_eq("t5_hazard_wb", hazard, 1);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_hazard_kept", hazard, 1);
        check_eq("t5_cnt_kept", pending_cnt, 1);
        tick();
        idle();

        // 6: index 0 never pends or writes; reset drops pending and wins over activity
        do_reset();
        issue_valid           = 1'b1;
        issue_rd              = 5'd0;
        src_valid             = 3'b100;
        src_idx[2*IW +: IW]   = 5'd0;
        src_data[2*DW +: DW]  = 32'h55;
        @(negedge clk);
        check_eq("t6_ready", src_ready, 3'b100);
        tick();
        idle();
        @(negedge clk);
        check_eq("t6_idx0", idx_write, 0);
        check_eq("t6_cnt0", pending_cnt, 0);
        for (int r = 1; r <= 3; r++) begin
            tick();
            issue_valid = 1'b1;
            issue_rd    = IW'(r);
        end
        tick();
        issue_valid = 1'b0;
        rs1         = 5'd1;
        rs2         = 5'd2;
        @(negedge clk);
        check_eq("t6_cnt3", pending_cnt, 3);
        tick();
        reset       = 1'b1;
        src_valid   = 3'b111;
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        @(negedge clk);
        check_eq("t6_ready_rst", src_ready, 0);
        check_eq("t6_hazard_rst", hazard, 0);
        tick();
        reset = 1'b0;
        idle();
        rs1 = 5'd1;
        rs2 = 5'd4;
        @(negedge clk);
        check_eq("t6_cnt_rst", pending_cnt, 0);
        check_eq("t6_hazard_after", hazard, 0);
        check_eq("t6_idx_rst", idx_write, 0);
        tick();
        tick();
        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
